// File: rtl/str_streamer.sv
// str_streamer: captures a packed string on go and hands it to a UART
// transmitter one character at a time, pacing on tx_busy. An optional
// CR or CR/LF terminator follows the string, and NUL characters can be
// skipped. Completion is flagged by a one-cycle done pulse.
module str_streamer #(
  parameter int N_CHARS  = 7,
  parameter int W        = 8,
  parameter int TERM     = 1,
  parameter int SKIP_NUL = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 abort,
  input  logic [N_CHARS*W-1:0] str,
  input  logic                 tx_busy,
  output logic [W-1:0]         dOut,
  output logic                 rdy,
  output logic                 busy,
  output logic                 done
);

  localparam int TLEN  = TERM;
  localparam int TOTAL = N_CHARS + TLEN;
  localparam int IDX_W = $clog2(N_CHARS + 3);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    STROBE,
    GAP,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N_CHARS*W-1:0]   snap_q, snap_d;
  logic [W-1:0]           dout_q, dout_d;
  logic                   rdy_q, busy_q, done_q;

  logic [W-1:0]           cur_char;
  logic [W-1:0]           symbol;
  logic                   is_char;

  // Select the captured string character addressed by idx (zero past the end).
  always_comb begin
    cur_char = '0;
    for (int i = 0; i < N_CHARS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_char = snap_q[i*W +: W];
      end
    end
  end

  // Map idx onto the full symbol stream: string characters, then CR, then LF.
  always_comb begin
    is_char = (idx_q < IDX_W'(N_CHARS));
    if (is_char) begin
      symbol = cur_char;
    end else if (idx_q == IDX_W'(N_CHARS)) begin
      symbol = W'(8'h0D);
    end else begin
      symbol = W'(8'h0A);
    end
  end

  // Sequencer next-state logic; abort preempts every other move.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    dout_d  = dout_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            snap_d  = str;
            idx_d   = '0;
            state_d = LOAD;
          end
        end
        LOAD: begin
          if (idx_q == IDX_W'(TOTAL)) begin
            state_d = DONE;
          end else if ((SKIP_NUL != 0) && is_char && (cur_char == '0)) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            dout_d  = symbol;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (!tx_busy) begin
            state_d = STROBE;
          end
        end
        STROBE: begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = GAP;
        end
        GAP: begin
          state_d = LOAD;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, datapath and state-decoded status flags, all cleared by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      dout_q  <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      dout_q  <= dout_d;
      rdy_q   <= (state_d == STROBE);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign dOut = dout_q;
  assign rdy  = rdy_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_str_streamer.sv
// Bench for str_streamer: default build, a two-character CR/LF build and a
// NUL-skipping build, driven with directed scenarios against hand timings.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_str_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_busy;
  logic        abort;

  logic        go_a;
  logic [55:0] str_a;
  logic [7:0]  dout_a;
  logic        rdy_a, busy_a, done_a;

  logic        go_h;
  logic [15:0] str_h;
  logic [7:0]  dout_h;
  logic        rdy_h, busy_h, done_h;

  logic        go_s;
  logic [55:0] str_s;
  logic [7:0]  dout_s;
  logic        rdy_s, busy_s, done_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  str_streamer dut_a (
    .clk(clk), .rst(rst), .go(go_a), .abort(abort), .str(str_a),
    .tx_busy(tx_busy), .dOut(dout_a), .rdy(rdy_a), .busy(busy_a), .done(done_a)
  );

  str_streamer #(.N_CHARS(2), .TERM(2)) dut_h (
    .clk(clk), .rst(rst), .go(go_h), .abort(abort), .str(str_h),
    .tx_busy(tx_busy), .dOut(dout_h), .rdy(rdy_h), .busy(busy_h), .done(done_h)
  );

  str_streamer #(.SKIP_NUL(1)) dut_s (
    .clk(clk), .rst(rst), .go(go_s), .abort(abort), .str(str_s),
    .tx_busy(tx_busy), .dOut(dout_s), .rdy(rdy_s), .busy(busy_s), .done(done_s)
  );

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({rdy_a, busy_a, done_a, dout_a} !== 11'd0) begin
      errors++; $display("[TB] FAIL reset_a got %h want 0", {rdy_a, busy_a, done_a, dout_a});
    end
    checks++;
    if ({rdy_h, busy_h, done_h, dout_h} !== 11'd0) begin
      errors++; $display("[TB] FAIL reset_h got %h want 0", {rdy_h, busy_h, done_h, dout_h});
    end
    checks++;
    if ({rdy_s, busy_s, done_s, dout_s} !== 11'd0) begin
      errors++; $display("[TB] FAIL reset_s got %h want 0", {rdy_s, busy_s, done_s, dout_s});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp_char [8];
    logic       exp_rdy;
    exp_char = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h0D};
    @(negedge clk);
    str_a = 56'h47464544434241;
    go_a  = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      go_a = 1'b0;
      exp_rdy = (c >= 3) && (c <= 31) && (((c - 3) % 4) == 0);
      checks++;
      if (rdy_a !== exp_rdy) begin
        errors++; $display("[TB] FAIL basic_rdy c=%0d got %b want %b", c, rdy_a, exp_rdy);
      end
      if (exp_rdy) begin
        checks++;
        if (dout_a !== exp_char[(c - 3) / 4]) begin
          errors++; $display("[TB] FAIL basic_dout c=%0d got %h want %h", c, dout_a, exp_char[(c - 3) / 4]);
        end
      end
      checks++;
      if (done_a !== (c == 34)) begin
        errors++; $display("[TB] FAIL basic_done c=%0d got %b want %b", c, done_a, (c == 34));
      end
      checks++;
      if (busy_a !== 1'b1) begin
        errors++; $display("[TB] FAIL basic_busy c=%0d got %b want 1", c, busy_a);
      end
      if (c == 2) str_a = 56'h0;
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_idle got %b want 0", busy_a);
    end
    str_a = 56'h67666564636261;
    go_a  = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      go_a = 1'b0;
      checks++;
      if (rdy_a !== (c == 3)) begin
        errors++; $display("[TB] FAIL b2b_rdy c=%0d got %b want %b", c, rdy_a, (c == 3));
      end
      checks++;
      if (busy_a !== (c <= 3)) begin
        errors++; $display("[TB] FAIL b2b_busy c=%0d got %b want %b", c, busy_a, (c <= 3));
      end
      if (c >= 3) begin
        checks++;
        if (dout_a !== 8'h61) begin
          errors++; $display("[TB] FAIL b2b_dout c=%0d got %h want 61", c, dout_a);
        end
      end
      if (c == 4) begin
        checks++;
        if (done_a !== 1'b0) begin
          errors++; $display("[TB] FAIL b2b_done got %b want 0", done_a);
        end
      end
      abort = (c == 3);
    end
  endtask

  task automatic test_hi();
    logic [7:0] exp_char [4];
    logic       exp_rdy;
    exp_char = '{8'h48, 8'h49, 8'h0D, 8'h0A};
    @(negedge clk);
    str_h = 16'h4948;
    go_h  = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      go_h = 1'b0;
      exp_rdy = (c >= 3) && (c <= 15) && (((c - 3) % 4) == 0);
      checks++;
      if (rdy_h !== exp_rdy) begin
        errors++; $display("[TB] FAIL hi_rdy c=%0d got %b want %b", c, rdy_h, exp_rdy);
      end
      if (exp_rdy) begin
        checks++;
        if (dout_h !== exp_char[(c - 3) / 4]) begin
          errors++; $display("[TB] FAIL hi_dout c=%0d got %h want %h", c, dout_h, exp_char[(c - 3) / 4]);
        end
      end
      checks++;
      if (done_h !== (c == 18)) begin
        errors++; $display("[TB] FAIL hi_done c=%0d got %b want %b", c, done_h, (c == 18));
      end
      checks++;
      if (busy_h !== (c <= 18)) begin
        errors++; $display("[TB] FAIL hi_busy c=%0d got %b want %b", c, busy_h, (c <= 18));
      end
    end
  endtask

  task automatic test_skip();
    logic       exp_rdy;
    logic [7:0] exp_char;
    int         n_rdy = 0;
    @(negedge clk);
    str_s = {8'h43, 8'h00, 8'h00, 8'h42, 8'h00, 8'h00, 8'h41};
    go_s  = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      go_s = 1'b0;
      exp_rdy = (c == 3) || (c == 9) || (c == 15) || (c == 19);
      case (c)
        3:       exp_char = 8'h41;
        9:       exp_char = 8'h42;
        15:      exp_char = 8'h43;
        19:      exp_char = 8'h0D;
        default: exp_char = 8'h00;
      endcase
      if (rdy_s === 1'b1) n_rdy++;
      checks++;
      if (rdy_s !== exp_rdy) begin
        errors++; $display("[TB] FAIL skip_rdy c=%0d got %b want %b", c, rdy_s, exp_rdy);
      end
      if (exp_rdy) begin
        checks++;
        if (dout_s !== exp_char) begin
          errors++; $display("[TB] FAIL skip_dout c=%0d got %h want %h", c, dout_s, exp_char);
        end
      end
      checks++;
      if (done_s !== (c == 22)) begin
        errors++; $display("[TB] FAIL skip_done c=%0d got %b want %b", c, done_s, (c == 22));
      end
    end
    checks++;
    if (n_rdy != 4) begin
      errors++; $display("[TB] FAIL skip_count got %0d want 4", n_rdy);
    end
  endtask

  // tx_busy is high during cycles 2..10, nine cycles spent waiting.
  task automatic test_tx_busy();
    logic [7:0] exp_char [8];
    logic       exp_rdy;
    exp_char = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h0D};
    @(negedge clk);
    str_a = 56'h47464544434241;
    go_a  = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      go_a = 1'b0;
      exp_rdy = (c >= 12) && (c <= 40) && (((c - 12) % 4) == 0);
      checks++;
      if (rdy_a !== exp_rdy) begin
        errors++; $display("[TB] FAIL txb_rdy c=%0d got %b want %b", c, rdy_a, exp_rdy);
      end
      if (exp_rdy) begin
        checks++;
        if (dout_a !== exp_char[(c - 12) / 4]) begin
          errors++; $display("[TB] FAIL txb_dout c=%0d got %h want %h", c, dout_a, exp_char[(c - 12) / 4]);
        end
      end
      checks++;
      if (done_a !== (c == 43)) begin
        errors++; $display("[TB] FAIL txb_done c=%0d got %b want %b", c, done_a, (c == 43));
      end
      if (c == 2)  tx_busy = 1'b1;
      if (c == 11) tx_busy = 1'b0;
    end
  endtask

  // Second WAIT is stretched by tx_busy so abort lands in it at cycle 8.
  task automatic test_abort();
    logic exp_rdy;
    logic exp_busy;
    @(negedge clk);
    str_a = 56'h47464544434241;
    go_a  = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      go_a  = 1'b0;
      abort = 1'b0;
      exp_rdy  = (c == 3) || ((c >= 12) && (c <= 40) && (((c - 12) % 4) == 0));
      exp_busy = ((c >= 1) && (c <= 8)) || ((c >= 10) && (c <= 43));
      checks++;
      if (rdy_a !== exp_rdy) begin
        errors++; $display("[TB] FAIL abort_rdy c=%0d got %b want %b", c, rdy_a, exp_rdy);
      end
      checks++;
      if (busy_a !== exp_busy) begin
        errors++; $display("[TB] FAIL abort_busy c=%0d got %b want %b", c, busy_a, exp_busy);
      end
      checks++;
      if (done_a !== (c == 43)) begin
        errors++; $display("[TB] FAIL abort_done c=%0d got %b want %b", c, done_a, (c == 43));
      end
      if (c == 9) begin
        checks++;
        if (dout_a !== 8'h42) begin
          errors++; $display("[TB] FAIL abort_hold c=%0d got %h want 42", c, dout_a);
        end
      end
      if (c == 12) begin
        checks++;
        if (dout_a !== 8'h41) begin
          errors++; $display("[TB] FAIL abort_restart c=%0d got %h want 41", c, dout_a);
        end
      end
      if (c == 5) tx_busy = 1'b1;
      if (c == 8) abort = 1'b1;
      if (c == 9) begin
        tx_busy = 1'b0;
        go_a    = 1'b1;
      end
    end
  endtask

  task automatic test_abort_go_idle();
    @(negedge clk);
    abort = 1'b1;
    go_a  = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      abort = 1'b0;
      go_a  = 1'b0;
      checks++;
      if ({busy_a, rdy_a, done_a} !== 3'b000) begin
        errors++; $display("[TB] FAIL abort_go c=%0d got %b want 000", c, {busy_a, rdy_a, done_a});
      end
    end
  endtask

  task automatic test_rst_mid();
    int n_rdy = 0;
    @(negedge clk);
    str_a = 56'h47464544434241;
    go_a  = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      go_a = (c == 5);
      if (rdy_a === 1'b1) n_rdy++;
      if (c == 7) begin
        checks++;
        if (dout_a !== 8'h42) begin
          errors++; $display("[TB] FAIL rst_go_ignored got %h want 42", dout_a);
        end
      end
    end
    checks++;
    if (n_rdy != 3) begin
      errors++; $display("[TB] FAIL rst_pre_count got %0d want 3", n_rdy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({rdy_a, busy_a, done_a, dout_a} !== 11'd0) begin
      errors++; $display("[TB] FAIL rst_async got %h want 0", {rdy_a, busy_a, done_a, dout_a});
    end
    #2;
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rdy_a === 1'b1) n_rdy++;
      checks++;
      if ({rdy_a, busy_a, done_a} !== 3'b000) begin
        errors++; $display("[TB] FAIL rst_after c=%0d got %b want 000", c, {rdy_a, busy_a, done_a});
      end
    end
    checks++;
    if (n_rdy != 3) begin
      errors++; $display("[TB] FAIL rst_post_count got %0d want 3", n_rdy);
    end
  endtask

  initial begin
    rst     = 1'b1;
    tx_busy = 1'b0;
    abort   = 1'b0;
    go_a    = 1'b0;
    go_h    = 1'b0;
    go_s    = 1'b0;
    str_a   = '0;
    str_h   = '0;
    str_s   = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_hi();
    test_skip();
    test_tx_busy();
    test_abort();
    test_abort_go_idle();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
